// File: rtl/blackboxjam_sdiv_30s_11ns_seq_pkg.sv
// blackboxjam_sdiv_30s_11ns_seq_pkg: shared widths and FSM encoding for the 30s/11u divider
package blackboxjam_sdiv_30s_11ns_seq_pkg;
  localparam int DIVIDEND_WIDTH = 30;
  localparam int DIVISOR_WIDTH = 11;
  localparam int CNT_W = 5;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/blackboxjam_div_step.sv
// blackboxjam_div_step: one restoring-division step on a 12-bit partial remainder
module blackboxjam_div_step
  import blackboxjam_sdiv_30s_11ns_seq_pkg::*;
(
  input  logic [DIVISOR_WIDTH:0]   prem,
  input  logic                     din,
  input  logic [DIVISOR_WIDTH-1:0] divisor,
  output logic [DIVISOR_WIDTH:0]   prem_next,
  output logic                     q
);
  logic [DIVISOR_WIDTH+2:0] diff;
  always_comb begin
    diff = {1'b0, prem, din} - {3'b0, divisor};
    // shifted value is < 4096, so a non-negative difference never sets bit 12
    q = ~(diff[DIVISOR_WIDTH+2] | diff[DIVISOR_WIDTH+1]);
    prem_next = q ? diff[DIVISOR_WIDTH:0] : {prem[DIVISOR_WIDTH-1:0], din};
  end
endmodule

// File: rtl/blackboxjam_sdiv_30s_11ns_seq.sv
// blackboxjam_sdiv_30s_11ns_seq: multi-cycle signed/unsigned restoring divider with valid/ready
module blackboxjam_sdiv_30s_11ns_seq
  import blackboxjam_sdiv_30s_11ns_seq_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ce,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [DIVIDEND_WIDTH-1:0] dividend,
  input  logic        [DIVISOR_WIDTH-1:0]  divisor,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [DIVIDEND_WIDTH-1:0] quotient,
  output logic signed [DIVISOR_WIDTH-1:0]  remainder,
  output logic                             div_by_zero
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [DIVIDEND_WIDTH-1:0] mag;
  logic [DIVISOR_WIDTH-1:0] dvs;
  logic [DIVISOR_WIDTH:0] prem, prem_next;
  logic neg, zero, qbit;
  blackboxjam_div_step u_step (
    .prem(prem),
    .din(mag[DIVIDEND_WIDTH-1]),
    .divisor(dvs),
    .prem_next(prem_next),
    .q(qbit)
  );
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    state_n = state;
    if (ce)
      unique case (state)
        IDLE: state_n = in_valid ? (divisor == '0 ? FIX : CALC) : IDLE;
        CALC: state_n = cnt == '0 ? FIX : CALC;
        FIX:  state_n = DONE;
        DONE: state_n = out_ready ? IDLE : DONE;
      endcase
  end
  // mag doubles as the quotient shift register: dividend bits leave at the top, quotient bits enter at the bottom
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      cnt <= '0;
      mag <= '0;
      dvs <= '0;
      prem <= '0;
      neg <= 1'b0;
      zero <= 1'b0;
    end else if (ce) begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        mag <= divisor == '0 ? '0 : (dividend[DIVIDEND_WIDTH-1] ? -dividend : dividend);
        neg <= dividend[DIVIDEND_WIDTH-1];
        dvs <= divisor;
        prem <= '0;
        cnt <= CNT_W'(DIVIDEND_WIDTH - 1);
        zero <= divisor == '0;
      end
      if (state == CALC) begin
        mag <= {mag[DIVIDEND_WIDTH-2:0], qbit};
        prem <= prem_next;
        cnt <= cnt - 1'b1;
      end
      if (state == FIX) begin
        quotient <= neg ? -mag : mag;
        remainder <= neg ? -prem[DIVISOR_WIDTH-1:0] : prem[DIVISOR_WIDTH-1:0];
        div_by_zero <= zero;
      end
    end
  end
endmodule
